// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
//
// Executes MULT, MULTU, DIV, DIVU (33-cycle shift-add / restoring divide) and
// MTHI, MTLO (single edge). Optional macro MDU_FAST_MUL_EN: MULT/MULTU finish
// in one cycle through a combinational 64-bit multiply; divides are unchanged.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - request, sampled only in IDLE
//   op    - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6/7 ignored)
//   a, b  - rs / rt operands
//   busy  - iterative operation in progress (PC stall)
//   done  - one-cycle pulse after HI/LO take a mul/div result
//   hi,lo - HI and LO registers
module mult_div_unit #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [ITER_W-1:0] LAST_STEP = ITER_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    opd_q, opd_d;          // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;  // product / quotient negation
    logic                neg_rem_q, neg_rem_d;  // remainder follows the dividend sign
    logic                dz_q, dz_d;            // divide by zero
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH:0]      add_sum;
    logic [2*WIDTH-1:0]  mul_next;
    logic [WIDTH:0]      div_shift, div_diff;
    logic [2*WIDTH-1:0]  div_next;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quot_fix, rem_fix;
`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0]  fast_prod;
`endif

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        // -32'h80000000 wraps to itself, which is the correct unsigned magnitude.
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        // Shift-add: conditionally add the multiplicand into the high half,
        // then shift the whole accumulator right by one.
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_next  = {add_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder,
        // trial-subtract, keep the difference only when it did not borrow.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opd_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`ifdef MDU_FAST_MUL_EN
        fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                            {hi_d, lo_d} = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
                            done_d       = 1'b1;
`else
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            opd_d     = a_mag;
                            is_div_d  = 1'b0;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            cnt_d     = '0;
                            state_d   = S_MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            opd_d     = b_mag;
                            is_div_d  = 1'b1;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = (b == '0);
                            cnt_d     = '0;
                            state_d   = S_DIV;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    // A zero divisor leaves |a| as remainder, so the sign fix
                    // already yields hi=a; only the quotient is forced.
                    lo_d = dz_q ? '1 : quot_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] prev_hi, prev_lo;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    mult_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_busy(input logic [2:0] o);
`ifdef MDU_FAST_MUL_EN
        return (o <= 3'd1) ? 0 : 33;
`else
        return 33;
`endif
    endfunction

    // Called at a negedge: drives the request, lets the accepting edge pass.
    task automatic start_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts busy cycles until done, checks stale HI/LO while busy and the
    // final result. Returns at the negedge where done is high.
    task automatic wait_result(input string name, input int nbusy,
                               input logic [31:0] ehi, input logic [31:0] elo);
        int  cnt = 0;
        bit  got = 0;
        bit  stale_ok = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            if (busy) begin
                cnt++;
                if (hi !== prev_hi || lo !== prev_lo) stale_ok = 0;
            end
        end
        check({name, " done seen"}, 32'(got), 32'd1);
        check({name, " busy cycles"}, 32'(cnt), 32'(nbusy));
        check({name, " hilo held while busy"}, 32'(stale_ok), 32'd1);
        check({name, " busy at done"}, 32'(busy), 32'd0);
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
    endtask

    initial begin
        vecs[0] = '{"mult -3*5",      3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{"multu ffff*2",   3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{"divu 100/7",     3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3] = '{"div -7/2",       3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{"div ovf",        3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{"divu 9/0",       3'd3, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF};
        vecs[6] = '{"div -7/0",       3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{"mult 7*-2",      3'd0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
        vecs[8] = '{"mult min*min",   3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9] = '{"div 7/-2",       3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // Back-to-back: each start after the first lands in the done cycle.
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(vecs[i].name, exp_busy(vecs[i].op), vecs[i].exp_hi, vecs[i].exp_lo);
        end
        @(negedge clk);
        check("done single pulse", 32'(done), 32'd0);

        // MTHI / MTLO: written at the accepting edge, no busy, no done.
        start_op(3'd4, 32'h12345678, 32'd0);
        @(negedge clk);
        check("mthi hi", hi, 32'h12345678);
        check("mthi busy", 32'(busy), 32'd0);
        check("mthi done", 32'(done), 32'd0);
        start_op(3'd5, 32'hCAFEF00D, 32'd0);
        @(negedge clk);
        check("mtlo lo", lo, 32'hCAFEF00D);
        check("mtlo hi kept", hi, 32'h12345678);
        check("mtlo done", 32'(done), 32'd0);

        // Reserved op: nothing changes.
        start_op(3'd6, 32'hDEADBEEF, 32'd1);
        @(negedge clk);
        check("rsvd busy", 32'(busy), 32'd0);
        check("rsvd hi", hi, 32'h12345678);
        check("rsvd lo", lo, 32'hCAFEF00D);

        // Second start during a division is ignored.
        start_op(3'd3, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_result("div with ignored start", 27, 32'd2, 32'd14);
        @(negedge clk);

        // Reset mid-division discards everything.
        start_op(3'd2, 32'hFFFFFFF9, 32'd2);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid busy", 32'(busy), 32'd0);
        check("rst mid done", 32'(done), 32'd0);
        check("rst mid hi", hi, 32'd0);
        check("rst mid lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_op(3'd3, 32'd100, 32'd7);
        wait_result("divu after reset", 33, 32'd2, 32'd14);
        start_op(3'd0, 32'hFFFFFFFD, 32'd5);
        wait_result("mult after reset", exp_busy(3'd0), 32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS single-cycle datapath.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits upstream of the 32-bit 8:1 write-back result mux; its `hi`/`lo` outputs feed two of the mux inputs for MFHI/MFLO.
- Control stalls the PC while `busy` is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- ITER_W, 6, width of the iteration counter; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved.
- a  input  32  rs operand; multiplicand, dividend, or MTHI/MTLO source.
- b  input  32  rt operand; multiplier or divisor.
- busy  output  1  high while an iterative operation is in progress.
- done  output  1  one-cycle pulse when HI/LO receive a mul/div result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset state: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset wins over every other input in the same cycle, including mid-operation: the partial result is discarded and HI/LO clear.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 with op 0/1: latch |a|, |b| (magnitudes for signed ops, raw values for unsigned) and the result-sign flags; counter=0; go to MUL; busy=1 next cycle.
  - start=1 with op 2/3: same latching, go to DIV.
  - start=1 with op 4: hi<=a at this edge; busy and done stay 0.
  - start=1 with op 5: lo<=a at this edge; busy and done stay 0.
  - Ops 6/7, or start=0: no change.
- MUL: one shift-add step per cycle on a 64-bit accumulator; counter increments. After 32 steps (counter==31 at the edge) go to FIX.
- DIV: one restoring shift-subtract step per cycle; same counter rule; then go to FIX.
- FIX, one cycle:
  - Apply two's-complement sign correction.
    - Product: negate if operand signs differ.
    - Quotient: negate if signs differ; truncate toward zero.
    - Remainder: takes the sign of the dividend.
  - Write hi/lo, raise done for exactly the following cycle, drop busy, return to IDLE.
- Latency: with start accepted at edge E0, busy is high in the 33 cycles following E0..E32. hi/lo update at E33, and done is high in the cycle following E33.
- Until the E33 write, hi/lo hold their previous values; the mux may read stale HI/LO while busy.
- start while busy=1 is ignored entirely. A start in the done cycle is legal and accepted (state is IDLE).
- Divide by zero (b==0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a. Same latency as a normal divide.
- Signed overflow (DIV, a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- Product: hi=upper 32 bits and lo=lower 32 bits of the 64-bit product.
- Division: lo=quotient, hi=remainder.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU complete in a single cycle using a combinational 64-bit multiply. hi/lo are written at the accepting edge E0, done is high in the following cycle, busy never rises, and the MUL state is not entered. DIV/DIVU are unchanged.
- Undefined: all multiplies use the 33-cycle iterative path described above.

Test Plan:
- Reset, then MULT a=32'hFFFFFFFD (-3), b=5 -> busy for 33 cycles, then done; hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. With MDU_FAST_MUL_EN: same values, done one cycle after start, busy stays 0.
- MULTU a=32'hFFFFFFFF, b=2 -> hi=1, lo=32'hFFFFFFFE.
- DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- DIVU a=9, b=0 -> lo=32'hFFFFFFFF, hi=9.
- MTHI a=32'h12345678 -> hi updates next edge; done and busy stay 0.
- Second start (op=1) issued mid-division -> ignored; the division result is unaffected.
- rst asserted 10 cycles into a DIV -> next cycle busy=0, done=0, hi=lo=0. A new start after release runs normally.
